cyclic_light_monitor: RTL and testbench
=======================================

Name: cyclic_light_monitor

Overview:
- Receive-side checker for the 3-bit cyclic lamp code stream (RED=3'b000, GREEN=3'b001, YELLOW=3'b010) driven by the team's cyclic light generator.
- Decodes each sampled code to one-hot lamp drives and verifies the legal sequence RED->GREEN->YELLOW->RED and the per-light dwell time.
- Counts completed cycles and errors.
- Sits between the light generator and the lamp drivers / status logic.

Parameters:
- MIN_DWELL, 1: minimum consecutive valid samples a light must hold before advancing (1..MAX_DWELL).
- MAX_DWELL, 1: maximum consecutive valid samples a light may hold (>=1, <=255).
- CNT_W, 8: width of cycle_count and err_count.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- light_code  input  3  lamp code from the generator.
- code_valid  input  1  light_code is sampled only when high.
- lamp_rgy  output  3  registered one-hot decode {red,green,yellow}.
- locked  output  1  high while the monitor is tracking a legal sequence.
- seq_error  output  1  one-cycle pulse on an order or dwell violation.
- illegal_code  output  1  one-cycle pulse when a valid code is not 000/001/010.
- cycle_count  output  CNT_W  completed YELLOW->RED cycles; saturates at all-ones.
- err_count  output  CNT_W  total seq_error + illegal_code events; saturates.

Behaviour:
- Reset (clock edge with reset=1):
  - lamp_rgy=3'b000, locked=0, seq_error=0, illegal_code=0, both counters=0.
  - FSM=HUNT, cur=RED, dwell=0.
  - Reset overrides any simultaneous valid sample.
- Latency: all outputs are registered. A sample at edge N is reflected after edge N.
- code_valid=0: no state or counter change. lamp_rgy holds. Pulses deassert.
- Decode on every valid sample, independent of FSM state:
  - 000->100, 001->010, 010->001.
  - Any other code -> 000.
- Illegal code (any state): illegal_code=1, err_count+1, FSM->HUNT, locked=0.
- FSM state HUNT (locked=0):
  - Valid RED -> LOCKED, cur=RED, dwell=1.
  - Valid GREEN or YELLOW: ignored, no error.
- FSM state LOCKED (locked=1), per valid sample with code c:
  - c==cur and dwell<MAX_DWELL: dwell+1.
  - c==cur and dwell==MAX_DWELL: seq_error, err_count+1, ->HUNT.
  - c==next(cur) and dwell>=MIN_DWELL: cur=c, dwell=1.
  - c==next(cur) and cur==YELLOW: additionally cycle_count+1.
  - c==next(cur) and dwell<MIN_DWELL: seq_error, err_count+1, ->HUNT.
  - Any other legal code (skip or reverse): seq_error, err_count+1, ->HUNT.
  - next(): RED->GREEN, GREEN->YELLOW, YELLOW->RED.
- Error sample handling:
  - The erroring sample is consumed; re-lock requires a later RED sample.
  - An erroring RED does not relock in the same edge.
- locked reflects the FSM state after each edge.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- seq_error and illegal_code are mutually exclusive per edge; illegal takes precedence.

Test Plan:
- Reset, then R,G,Y,R,G,Y,R every cycle, valid=1 (defaults) -> locked=1 one cycle after the first R; cycle_count=2; err_count=0; lamp_rgy tracks 100,010,001.
- Locked stream R,G then R -> seq_error pulse one cycle; locked=0; err_count=1; next G,Y ignored; next R relocks.
- Locked stream, then code 3'b111 -> illegal_code=1, lamp_rgy=000, locked=0, err_count=1, seq_error=0.
- MIN_DWELL=2, MAX_DWELL=3: R,R,G,G,G,Y,Y,R -> no error, cycle_count=1. Separately, R,G -> seq_error. Separately, R,R,R,R -> seq_error on the 4th R.
- Stream R,G with valid toggling 1,0,1,0 and garbage codes while valid=0 -> garbage ignored; no error; lamp_rgy holds across invalid cycles.
- Mid-stream reset asserted together with a valid Y -> all outputs 0, FSM=HUNT. With CNT_W=2, five full cycles -> cycle_count saturates at 3.

Source files
------------

// File: rtl/cyclic_light_monitor.sv
// Receive-side checker for the RED/GREEN/YELLOW cyclic lamp code stream.
// Decodes each valid sample to one-hot lamp drives and checks order, dwell and code legality.
module cyclic_light_monitor #(
    parameter int MIN_DWELL = 1,
    parameter int MAX_DWELL = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       light_code,
    input  logic             code_valid,
    output logic [2:0]       lamp_rgy,
    output logic             locked,
    output logic             seq_error,
    output logic             illegal_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] err_count,
    output logic             dbg_state
);

    typedef enum logic {HUNT = 1'b0, TRACK = 1'b1} state_e;

    localparam logic [1:0] C_RED    = 2'd0;
    localparam logic [1:0] C_GREEN  = 2'd1;
    localparam logic [1:0] C_YELLOW = 2'd2;
    localparam logic [7:0] MIN_D    = 8'(MIN_DWELL);
    localparam logic [7:0] MAX_D    = 8'(MAX_DWELL);

    state_e           state_q, state_d;
    logic [1:0]       cur_q, cur_d;
    logic [7:0]       dwell_q, dwell_d;
    logic [2:0]       lamp_q, lamp_d;
    logic             seq_q, seq_d;
    logic             ill_q, ill_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] err_q, err_d;

    logic       legal;
    logic [1:0] code;
    logic [1:0] next_cur;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign code  = light_code[1:0];
    assign legal = !light_code[2] && (code != 2'b11);

    always_comb begin
        case (cur_q)
            C_RED:   next_cur = C_GREEN;
            C_GREEN: next_cur = C_YELLOW;
            default: next_cur = C_RED;
        endcase
    end

    // State register: every piece of state, including the registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= HUNT;
            cur_q   <= C_RED;
            dwell_q <= 8'd0;
            lamp_q  <= 3'b000;
            seq_q   <= 1'b0;
            ill_q   <= 1'b0;
            cyc_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            dwell_q <= dwell_d;
            lamp_q  <= lamp_d;
            seq_q   <= seq_d;
            ill_q   <= ill_d;
            cyc_q   <= cyc_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: an erroring sample always lands in HUNT and is never reused to relock.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        dwell_d = dwell_q;
        lamp_d  = lamp_q;
        seq_d   = 1'b0;
        ill_d   = 1'b0;
        cyc_d   = cyc_q;
        err_d   = err_q;
        if (code_valid) begin
            case (light_code)
                3'b000:  lamp_d = 3'b100;
                3'b001:  lamp_d = 3'b010;
                3'b010:  lamp_d = 3'b001;
                default: lamp_d = 3'b000;
            endcase
            if (!legal) begin
                ill_d   = 1'b1;
                err_d   = sat_inc(err_q);
                state_d = HUNT;
                dwell_d = 8'd0;
            end else if (state_q == HUNT) begin
                if (code == C_RED) begin
                    state_d = TRACK;
                    cur_d   = C_RED;
                    dwell_d = 8'd1;
                end
            end else if (code == cur_q && dwell_q < MAX_D) begin
                dwell_d = dwell_q + 8'd1;
            end else if (code == next_cur && code != cur_q && dwell_q >= MIN_D) begin
                cur_d   = code;
                dwell_d = 8'd1;
                if (cur_q == C_YELLOW) begin
                    cyc_d = sat_inc(cyc_q);
                end
            end else begin
                seq_d   = 1'b1;
                err_d   = sat_inc(err_q);
                state_d = HUNT;
                dwell_d = 8'd0;
            end
        end
    end

    always_comb begin
        locked       = (state_q == TRACK);
        dbg_state    = state_q;
        lamp_rgy     = lamp_q;
        seq_error    = seq_q;
        illegal_code = ill_q;
        cycle_count  = cyc_q;
        err_count    = err_q;
    end

endmodule

// File: tb/tb_cyclic_light_monitor.sv
// Directed bench for cyclic_light_monitor: a vector table on the default build, plus
// hand sequences on a MIN_DWELL=2/MAX_DWELL=3 build and a CNT_W=2 build sharing the same inputs.
module tb_cyclic_light_monitor;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] light_code;
  logic       code_valid;

  logic [2:0] lamp_a, lamp_d, lamp_s;
  logic       lock_a, lock_d, lock_s;
  logic       seq_a, seq_d, seq_s;
  logic       ill_a, ill_d, ill_s;
  logic [7:0] cyc_a, err_a, cyc_d, err_d;
  logic [1:0] cyc_s, err_s;
  logic       st_a, st_d, st_s;

  int n_pass = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  cyclic_light_monitor dut (
    .clock(clock), .reset(reset), .light_code(light_code), .code_valid(code_valid),
    .lamp_rgy(lamp_a), .locked(lock_a), .seq_error(seq_a), .illegal_code(ill_a),
    .cycle_count(cyc_a), .err_count(err_a), .dbg_state(st_a)
  );

  cyclic_light_monitor #(.MIN_DWELL(2), .MAX_DWELL(3), .CNT_W(8)) dut_dw (
    .clock(clock), .reset(reset), .light_code(light_code), .code_valid(code_valid),
    .lamp_rgy(lamp_d), .locked(lock_d), .seq_error(seq_d), .illegal_code(ill_d),
    .cycle_count(cyc_d), .err_count(err_d), .dbg_state(st_d)
  );

  cyclic_light_monitor #(.MIN_DWELL(1), .MAX_DWELL(1), .CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .light_code(light_code), .code_valid(code_valid),
    .lamp_rgy(lamp_s), .locked(lock_s), .seq_error(seq_s), .illegal_code(ill_s),
    .cycle_count(cyc_s), .err_count(err_s), .dbg_state(st_s)
  );

  typedef struct {
    logic       rst;
    logic       vld;
    logic [2:0] code;
    logic [2:0] lamp;
    logic       lck;
    logic       seq;
    logic       ill;
    logic [7:0] cyc;
    logic [7:0] err;
  } vec_t;

  vec_t vecs[32];
  int   n_vec = 0;

  task automatic add(input logic rst, input logic vld, input logic [2:0] code,
                     input logic [2:0] lamp, input logic lck, input logic seq,
                     input logic ill, input logic [7:0] cyc, input logic [7:0] err);
    vecs[n_vec] = '{rst, vld, code, lamp, lck, seq, ill, cyc, err};
    n_vec++;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic drive(input logic rst, input logic vld, input logic [2:0] code);
    @(negedge clock);
    reset      = rst;
    code_valid = vld;
    light_code = code;
    @(posedge clock);
    #1;
  endtask

  localparam logic [2:0] R = 3'b000, G = 3'b001, Y = 3'b010;

  initial begin
    reset = 1'b1;
    code_valid = 1'b0;
    light_code = 3'b000;

    //   rst vld code  lamp    lck seq ill cyc err
    add(1, 0, R,      3'b000, 0, 0, 0, 0, 0);
    add(0, 1, R,      3'b100, 1, 0, 0, 0, 0);
    add(0, 1, G,      3'b010, 1, 0, 0, 0, 0);
    add(0, 1, Y,      3'b001, 1, 0, 0, 0, 0);
    add(0, 1, R,      3'b100, 1, 0, 0, 1, 0);
    add(0, 1, G,      3'b010, 1, 0, 0, 1, 0);
    add(0, 1, Y,      3'b001, 1, 0, 0, 1, 0);
    add(0, 1, R,      3'b100, 1, 0, 0, 2, 0);
    add(0, 1, G,      3'b010, 1, 0, 0, 2, 0);
    add(0, 1, R,      3'b100, 0, 1, 0, 2, 1);
    add(0, 1, G,      3'b010, 0, 0, 0, 2, 1);
    add(0, 1, Y,      3'b001, 0, 0, 0, 2, 1);
    add(0, 1, R,      3'b100, 1, 0, 0, 2, 1);
    add(0, 1, 3'b111, 3'b000, 0, 0, 1, 2, 2);
    add(0, 1, R,      3'b100, 1, 0, 0, 2, 2);
    add(0, 0, 3'b111, 3'b100, 1, 0, 0, 2, 2);
    add(0, 1, G,      3'b010, 1, 0, 0, 2, 2);
    add(0, 0, 3'b101, 3'b010, 1, 0, 0, 2, 2);
    add(0, 1, Y,      3'b001, 1, 0, 0, 2, 2);
    add(0, 1, R,      3'b100, 1, 0, 0, 3, 2);
    add(0, 1, R,      3'b100, 0, 1, 0, 3, 3);
    add(0, 1, R,      3'b100, 1, 0, 0, 3, 3);
    add(0, 1, Y,      3'b001, 0, 1, 0, 3, 4);
    add(1, 1, Y,      3'b000, 0, 0, 0, 0, 0);
    add(0, 1, Y,      3'b001, 0, 0, 0, 0, 0);

    for (int i = 0; i < n_vec; i++) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].code);
      chk($sformatf("v%0d lamp_rgy", i),     {5'd0, lamp_a}, {5'd0, vecs[i].lamp});
      chk($sformatf("v%0d locked", i),       {7'd0, lock_a}, {7'd0, vecs[i].lck});
      chk($sformatf("v%0d seq_error", i),    {7'd0, seq_a},  {7'd0, vecs[i].seq});
      chk($sformatf("v%0d illegal_code", i), {7'd0, ill_a},  {7'd0, vecs[i].ill});
      chk($sformatf("v%0d cycle_count", i),  cyc_a, vecs[i].cyc);
      chk($sformatf("v%0d err_count", i),    err_a, vecs[i].err);
    end
    chk("reset fsm hunt", {7'd0, st_a}, 8'd0);

    // Dwell window 2..3: a legal slow cycle produces no error and one completed cycle.
    drive(1, 0, R);
    begin
      logic [2:0] seq_codes[8];
      seq_codes = '{R, R, G, G, G, Y, Y, R};
      for (int i = 0; i < 8; i++) begin
        drive(0, 1, seq_codes[i]);
        chk($sformatf("dw slow %0d seq_error", i), {7'd0, seq_d}, 8'd0);
      end
    end
    chk("dw slow cycle_count", cyc_d, 8'd1);
    chk("dw slow err_count", err_d, 8'd0);
    chk("dw slow locked", {7'd0, lock_d}, 8'd1);

    // Advancing after only one sample is below MIN_DWELL.
    drive(1, 0, R);
    drive(0, 1, R);
    drive(0, 1, G);
    chk("dw short seq_error", {7'd0, seq_d}, 8'd1);
    chk("dw short locked", {7'd0, lock_d}, 8'd0);
    chk("dw short err_count", err_d, 8'd1);

    // Holding RED for a fourth sample exceeds MAX_DWELL.
    drive(1, 0, R);
    drive(0, 1, R);
    drive(0, 1, R);
    drive(0, 1, R);
    chk("dw long 3rd seq_error", {7'd0, seq_d}, 8'd0);
    chk("dw long 3rd locked", {7'd0, lock_d}, 8'd1);
    drive(0, 1, R);
    chk("dw long 4th seq_error", {7'd0, seq_d}, 8'd1);
    chk("dw long 4th locked", {7'd0, lock_d}, 8'd0);
    drive(0, 1, G);
    chk("dw long pulse clears", {7'd0, seq_d}, 8'd0);

    // Two-bit cycle counter saturates at 3 after five completed cycles.
    drive(1, 0, R);
    drive(0, 1, R);
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, G);
      drive(0, 1, Y);
      drive(0, 1, R);
      if (k == 2) chk("sat after 3 cycles", {6'd0, cyc_s}, 8'd3);
    end
    chk("sat cycle_count", {6'd0, cyc_s}, 8'd3);
    chk("sat err_count", {6'd0, err_s}, 8'd0);
    chk("sat locked", {7'd0, lock_s}, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
